// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Streams a program image, one byte per handshake, into instruction memory.
//   Bytes are packed little-endian into 32-bit words. Each complete word is
//   written with a one-cycle strobe at consecutive addresses starting at
//   BASE_ADDR. The CPU is held off while a load is in progress.
//
// Parameters
//   BASE_ADDR  : address of the first word written
//   ADDR_STEP  : byte increment of im_addr after each word write
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-low reset
//   load_start in   1   one-cycle load request (accepted in IDLE/DONE)
//   word_count in  16   words to load, sampled with load_start
//   in_valid   in   1   source byte valid
//   in_data    in   8   source byte
//   in_ready   out  1   loader accepts a byte this cycle
//   im_we      out  1   instruction-memory write strobe
//   im_addr    out 32   instruction-memory write address
//   im_wdata   out 32   instruction-memory write data
//   busy       out  1   load in progress
//   cpu_hold   out  1   keeps the CPU stalled while high
//   done       out  1   sticky load-complete flag
//   err        out  1   sticky checksum-mismatch flag
//
// Build option
//   IMEM_LOADER_CHECKSUM_EN : after the last word, one trailer byte is
//   accepted and compared against the 8-bit sum of all data bytes.
//   Undefined: no trailer is consumed and err stays 0.
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic [15:0] word_count,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_count;
    logic [1:0]  r_idx;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_done;
    logic        w_last_word;

    assign w_last_word = (r_count == 16'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        im_we        = 1'b0;
        busy         = 1'b0;
        cpu_hold     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (load_start) begin
                    w_state_next = (word_count == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (in_valid && (r_idx == 2'd3)) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                im_we    = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_state_next = S_CHECK;
`else
                    w_state_next = S_DONE;
`endif
                end else begin
                    w_state_next = S_COLLECT;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (in_valid) begin
                    w_state_next = S_DONE;
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_err;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_idx   <= '0;
            r_addr  <= BASE_ADDR;
            r_wdata <= '0;
            r_done  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (load_start) begin
                        r_count <= word_count;
                        r_idx   <= '0;
                        r_addr  <= BASE_ADDR;
                        // A zero-length load goes straight back to DONE,
                        // so done is re-asserted on the same edge.
                        r_done  <= (word_count == '0);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum   <= '0;
                        r_err   <= 1'b0;
`endif
                    end
                end
                S_COLLECT: begin
                    if (in_valid) begin
                        r_wdata[{r_idx, 3'b000} +: 8] <= in_data;
                        r_idx <= r_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum <= r_sum + in_data;
`endif
                    end
                end
                S_WRITE: begin
                    r_addr  <= r_addr + ADDR_STEP;
                    r_count <= r_count - 16'd1;
`ifndef IMEM_LOADER_CHECKSUM_EN
                    if (w_last_word) begin
                        r_done <= 1'b1;
                    end
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (in_valid) begin
                        r_err  <= (in_data != r_sum);
                        r_done <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign im_addr  = r_addr;
    assign im_wdata = r_wdata;
    assign done     = r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err      = r_err;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed self-checking bench for imem_loader. Inputs are driven 1 ns after
//   the rising edge; outputs are checked at the same point. Writes are logged
//   on the falling edge. Builds with or without IMEM_LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        load_start;
    logic [15:0] word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        err;

    imem_loader #(
        .BASE_ADDR(32'h0000_0000),
        .ADDR_STEP(32'd4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [7:0]  tb_sum;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int unsigned wr_cyc[$];
    int unsigned cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (im_we === 1'b1) begin
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic start_load(input logic [15:0] n);
        load_start = 1'b1;
        word_count = n;
        tb_sum     = 8'h00;
        tick();
        load_start = 1'b0;
        word_count = 16'h0;
    endtask

    // Holds the byte until in_ready, then lets it transfer on the next edge.
    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("ready_wait", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        tb_sum   = tb_sum + b;
    endtask

    task automatic send_gapped(input logic [7:0] b);
        in_valid = 1'b0;
        tick();
        send_byte(b);
    endtask

    // Trailer byte only exists when the checksum option is built in.
    task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] t;
        t = tb_sum;
        send_byte(t);
`else
        tick();
`endif
    endtask

    initial begin
        reset      = 1'b0;
        load_start = 1'b0;
        word_count = 16'h0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        tb_sum     = 8'h00;
        #23;
        check("rst_ready", {31'b0, in_ready}, 32'd0);
        check("rst_we",    {31'b0, im_we},    32'd0);
        check("rst_addr",  im_addr,           32'h0);
        check("rst_wdata", im_wdata,          32'h0);
        check("rst_busy",  {31'b0, busy},     32'd0);
        check("rst_hold",  {31'b0, cpu_hold}, 32'd0);
        check("rst_done",  {31'b0, done},     32'd0);
        check("rst_err",   {31'b0, err},      32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        // Single word 13,00,00,20.
        clear_log();
        start_load(16'd1);
        check("w1_busy",  {31'b0, busy},     32'd1);
        check("w1_hold",  {31'b0, cpu_hold}, 32'd1);
        check("w1_ready", {31'b0, in_ready}, 32'd1);
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h20);
        check("w1_we",    {31'b0, im_we},    32'd1);
        check("w1_addr",  im_addr,           32'h0);
        check("w1_data",  im_wdata,          32'h2000_0013);
        check("w1_wbusy", {31'b0, busy},     32'd1);
        finish_load();
        check("w1_done",  {31'b0, done},     32'd1);
        check("w1_idle",  {31'b0, busy},     32'd0);
        check("w1_we0",   {31'b0, im_we},    32'd0);
        check("w1_err",   {31'b0, err},      32'd0);
        check("w1_nrdy",  {31'b0, in_ready}, 32'd0);
        check("w1_nwr",   wr_addr.size(),    32'd1);

        // Three words, continuous stream, restart from DONE.
        clear_log();
        start_load(16'd3);
        check("w3_dclr", {31'b0, done}, 32'd0);
        for (int i = 0; i < 12; i++) send_byte(8'h11 + 8'(i));
        finish_load();
        check("w3_nwr", wr_addr.size(), 32'd3);
        if (wr_addr.size() == 3) begin
            check("w3_a0", wr_addr[0], 32'h0);
            check("w3_a1", wr_addr[1], 32'h4);
            check("w3_a2", wr_addr[2], 32'h8);
            check("w3_d0", wr_data[0], 32'h1413_1211);
            check("w3_d1", wr_data[1], 32'h1817_1615);
            check("w3_d2", wr_data[2], 32'h1C1B_1A19);
            check("w3_gap1", wr_cyc[1] - wr_cyc[0], 32'd5);
            check("w3_gap2", wr_cyc[2] - wr_cyc[1], 32'd5);
        end
        check("w3_done", {31'b0, done},  32'd1);
        check("w3_hold", {31'b0, cpu_hold}, 32'd0);
        check("w3_addr", im_addr, 32'hC);

        // Two words with in_valid toggling.
        clear_log();
        start_load(16'd2);
        for (int i = 0; i < 8; i++) send_gapped(8'hA0 + 8'(i));
        finish_load();
        check("tg_nwr", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            check("tg_a0", wr_addr[0], 32'h0);
            check("tg_a1", wr_addr[1], 32'h4);
            check("tg_d0", wr_data[0], 32'hA3A2_A1A0);
            check("tg_d1", wr_data[1], 32'hA7A6_A5A4);
        end
        check("tg_done", {31'b0, done}, 32'd1);

        // Reset after 2 bytes of word 1.
        clear_log();
        start_load(16'd2);
        for (int i = 0; i < 6; i++) send_byte(8'h51 + 8'(i));
        reset = 1'b0;
        #1;
        check("ar_ready", {31'b0, in_ready}, 32'd0);
        check("ar_we",    {31'b0, im_we},    32'd0);
        check("ar_addr",  im_addr,           32'h0);
        check("ar_wdata", im_wdata,          32'h0);
        check("ar_busy",  {31'b0, busy},     32'd0);
        check("ar_hold",  {31'b0, cpu_hold}, 32'd0);
        check("ar_done",  {31'b0, done},     32'd0);
        tick();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        tick();
        tick();
        tick();
        check("ar_nrdy",  {31'b0, in_ready}, 32'd0);
        check("ar_nbusy", {31'b0, busy},     32'd0);
        in_valid = 1'b0;
        check("ar_nwr",   wr_addr.size(),    32'd1);
        start_load(16'd1);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        finish_load();
        check("ar_nwr2", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            check("ar_a1", wr_addr[1], 32'h0);
            check("ar_d1", wr_data[1], 32'h1234_5678);
        end

        // Zero-length load.
        clear_log();
        start_load(16'd0);
        check("z_ready", {31'b0, in_ready}, 32'd0);
        check("z_busy",  {31'b0, busy},     32'd0);
        tick();
        check("z_done",  {31'b0, done},     32'd1);
        check("z_nwr",   wr_addr.size(),    32'd0);

        // load_start while busy is ignored.
        clear_log();
        start_load(16'd1);
        send_byte(8'hC1);
        load_start = 1'b1;
        word_count = 16'd5;
        tick();
        load_start = 1'b0;
        word_count = 16'd0;
        check("ig_busy", {31'b0, busy}, 32'd1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        send_byte(8'hC4);
        finish_load();
        check("ig_nwr",  wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            check("ig_d0", wr_data[0], 32'hC4C3_C2C1);
        end
        check("ig_done", {31'b0, done}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum: 01+02+03+04 = 0A.
        start_load(16'd1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        tick();
        check("ck_inchk", {31'b0, in_ready}, 32'd1);
        check("ck_ndone", {31'b0, done},     32'd0);
        send_byte(8'h0A);
        check("ck_err0",  {31'b0, err},      32'd0);
        check("ck_done0", {31'b0, done},     32'd1);
        start_load(16'd1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h0B);
        check("ck_err1",  {31'b0, err},      32'd1);
        check("ck_done1", {31'b0, done},     32'd1);
        start_load(16'd1);
        check("ck_eclr",  {31'b0, err},      32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
